pipe_queue: RTL and testbench
=============================

# pipe_queue

Elastic decoupling queue that terminates the valid/allow pipeline handshake on its input side and re-issues it on its output side. It sits behind a pipeline stage register, for example between fetch and decode. It absorbs downstream stalls so the upstream stage keeps advancing until the queue fills. It also gives the downstream stage a registered, flushable, in-order stream that shows `nop_data` whenever it is empty.

## Interface
Parameters:
- `WIDTH`, 100, payload width in bits.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `aclk`  in  1  clock; all state updates on the rising edge.
  - `areset`  in  1  asynchronous, active-high reset.
- Upstream side (connects to the stage's output handshake):
  - `flush`  in  1  synchronous clear of all queued entries.
  - `in_valid`  in  1  upstream stage holds a valid payload (its `valid_out`).
  - `in_data`  in  WIDTH  upstream payload.
  - `in_allow`  out  1  queue can accept this cycle (drives upstream `allow_in`).
- Downstream side:
  - `out_valid`  out  1  head entry presented.
  - `out_data`  out  WIDTH  head payload, or `nop_data` when `out_valid`=0.
  - `out_allow`  in  1  downstream accepts the head this cycle.
  - `nop_data`  in  WIDTH  bubble payload shown when nothing is presented.
- Status:
  - `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage:
  - Circular buffer of DEPTH entries.
  - `wr_ptr`/`rd_ptr` are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
  - `count` = `wr_ptr` − `rd_ptr`, computed modulo 2^(ptr width).
- Push and pop:
  - `push` = `in_valid` && `in_allow`; writes `in_data` at `wr_ptr`, then `wr_ptr`+1.
  - `pop` = `out_valid` && `out_allow`; `rd_ptr`+1.
  - Simultaneous push and pop: both pointers advance and `count` is unchanged.
- Handshake outputs:
  - `in_allow` = !full && !flush. It has no combinational dependency on `out_allow`, so a full queue rejects a push even while it is popping.
  - `out_valid` = !empty && !flush.
  - `out_data` = entry at `rd_ptr` when `out_valid`, else `nop_data`.
- Flush:
  - At the next edge both pointers are set to 0 and `count` becomes 0.
  - Push and pop are both suppressed during the flush cycle.
  - Flush takes priority over push and pop.
- Hold: entry contents never change while they are queued; only the `wr_ptr` slot is written.
- Wrap-around: pointers roll over naturally at 2^(ptr width); there is no special case.

## Timing
- Reset (async assert, sync-safe deassert):
  - `wr_ptr`=`rd_ptr`=0, so `count`=0.
  - `out_valid`=0, `out_data`=`nop_data`.
  - `in_allow`=1 once `areset` deasserts.
  - Storage contents are don't-care.
- Latency (bypass not compiled in): a push in cycle N is visible as `out_valid` in cycle N+1.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH−1.
- Full boundary: `in_allow`=0 for the whole cycle; it rises in the cycle after the first pop.
- Empty boundary: `out_valid`=0; `out_allow` is ignored.
- Reset mid-operation: all queued entries are discarded immediately; no partial pop occurs.

## Configuration
- Macro: `PIPE_QUEUE_BYPASS_EN`.
- Defined:
  - When the queue is empty, not flushing and `in_valid`=1, then `out_valid`=1 and `out_data`=`in_data` combinationally (zero latency).
  - If `out_allow`=1 in that cycle, the payload is consumed directly and not written; `count` stays 0.
  - If `out_allow`=0, it is written normally.
- Undefined: there is no combinational path from `in_*` to `out_*`; minimum latency is 1 cycle.

## Structure
- Shared package `cpuDefine`:
  - `PIPE_QUEUE_DEPTH` default constant.
  - Typedef `queue_ptr_t` sized from it.
- Pointer and full/empty logic stay local to `pipe_queue`.
- One sub-module, `pipe_queue_ram`:
  - DEPTH×WIDTH register array.
  - Single write port (`we`, `waddr`, `wdata`) and one asynchronous read port.
  - No reset on contents.

## Test plan
- Reset, then drive `in_valid`=1 with data 0x11, 0x22, 0x33 and hold `out_allow`=1 → `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles starting one cycle after the first push; `count` never exceeds 1.
- `out_allow`=0 while pushing 5 items with DEPTH=4 → `in_allow` falls after the 4th push and `count`=4; the 5th item is held upstream. Raise `out_allow` → order is 1,2,3,4,5 with no loss or duplicate.
- Full queue with `in_valid`=1 and `out_allow`=1 in the same cycle → only the pop happens; `count` goes 4→3; `in_allow`=1 the next cycle.
- `flush` pulse with `count`=3 → `out_valid`=0 and `out_data`=`nop_data` (0xDEAD) during the flush cycle; `count`=0 the next cycle; a following push of 0x44 appears as the head.
- Run 3×DEPTH+1 push/pop pairs to wrap the pointers → data order is preserved and `count` stays correct across the wrap.
- With `PIPE_QUEUE_BYPASS_EN`: empty queue, `in_valid`=1 with 0x55 and `out_allow`=1 → `out_valid`=1 with `out_data`=0x55 in the same cycle; `count` stays 0.

Source files
------------

// File: rtl/pipe_queue_pkg.sv
// rtl/pipe_queue_pkg.sv - shared constants and types for pipe_queue
// Purpose : default queue depth and the pointer type sized from it.
// Ports   : none (package cpuDefine).
package cpuDefine;

  localparam int PIPE_QUEUE_DEPTH = 4;
  localparam int PIPE_QUEUE_PTR_W = $clog2(PIPE_QUEUE_DEPTH) + 1;

  // Pointer with one extra wrap bit above the slot index.
  typedef logic [PIPE_QUEUE_PTR_W-1:0] queue_ptr_t;

endpackage

// File: rtl/pipe_queue_ram.sv
// rtl/pipe_queue_ram.sv - DEPTH x WIDTH storage for pipe_queue
// Purpose : register array with one write port and one asynchronous read port.
// Ports   : clk                - write clock
//           we, waddr, wdata   - write port (written on rising edge when we=1)
//           raddr, rdata       - asynchronous read port
// Contents are not reset; occupancy tracking lives in the parent.
module pipe_queue_ram #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipe_queue.sv
// rtl/pipe_queue.sv - elastic valid/allow decoupling queue
// Purpose : absorbs downstream stalls behind a pipeline stage and re-issues a
//           registered, flushable, in-order stream; shows nop_data when empty.
// Ports   : aclk, areset            - clock, async active-high reset
//           flush                   - synchronous clear of all entries
//           in_valid, in_data       - upstream payload handshake
//           in_allow                - queue accepts this cycle
//           out_valid, out_data     - head entry (nop_data when not valid)
//           out_allow               - downstream accepts the head
//           nop_data                - bubble payload
//           count                   - current occupancy
// Config  : PIPE_QUEUE_BYPASS_EN - zero-latency pass-through when empty.
module pipe_queue
  import cpuDefine::*;
#(
  parameter int WIDTH = 100,
  parameter int DEPTH = PIPE_QUEUE_DEPTH
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_allow,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_allow,
  input  logic [WIDTH-1:0]         nop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_head_ok;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  // Same slot index on opposite laps means full; identical pointers mean empty.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_head_ok = !w_empty && !flush;

  assign in_allow  = !w_full && !flush;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign w_pop     = w_head_ok && out_allow;

`ifdef PIPE_QUEUE_BYPASS_EN
  logic w_bypass;

  // Empty queue forwards the incoming payload; if it is taken right away it
  // never occupies a slot.
  assign w_bypass  = w_empty && !flush && in_valid;
  assign out_valid = w_head_ok || w_bypass;
  assign out_data  = w_head_ok ? w_rdata : (w_bypass ? in_data : nop_data);
  assign w_push    = in_valid && in_allow && !(w_bypass && out_allow);
`else
  assign out_valid = w_head_ok;
  assign out_data  = w_head_ok ? w_rdata : nop_data;
  assign w_push    = in_valid && in_allow;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  pipe_queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (w_push),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_rdata)
  );

endmodule

// File: tb/tb_pipe_queue.sv
// tb/tb_pipe_queue.sv - self-checking bench for pipe_queue
module tb_pipe_queue;

  localparam int WIDTH = 100;
  localparam int DEPTH = 4;

  logic             aclk = 1'b0;
  logic             areset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_allow;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_allow;
  logic [WIDTH-1:0] nop_data;
  logic [2:0]       count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] q[$];
  logic             mon_en = 1'b0;

  pipe_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_allow  (in_allow),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_allow (out_allow),
    .nop_data  (nop_data),
    .count     (count)
  );

  always #5 aclk = ~aclk;

  function automatic void check(input string name, input logic [WIDTH-1:0] act,
                                input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [WIDTH-1:0] rnd_data();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[WIDTH-1:0];
  endfunction

  // Reference model: an ordered list of queued payloads. Outputs are derived
  // from its size and head; it advances using the inputs held for the cycle.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (areset) begin
        q.delete();
        check("rst_count", WIDTH'(count), '0);
        check("rst_out_valid", WIDTH'(out_valid), '0);
        check("rst_out_data", out_data, nop_data);
      end else begin
        logic             exp_allow;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        exp_allow = (q.size() < DEPTH) && !flush;
        exp_valid = (q.size() > 0) && !flush;
        exp_data  = exp_valid ? q[0] : nop_data;
        check("in_allow", WIDTH'(in_allow), WIDTH'(exp_allow));
        check("out_valid", WIDTH'(out_valid), WIDTH'(exp_valid));
        check("out_data", out_data, exp_data);
        check("count", WIDTH'(count), WIDTH'(q.size()));
        if (flush) begin
          q.delete();
        end else begin
          if (exp_valid && out_allow) void'(q.pop_front());
          if (in_valid && exp_allow) q.push_back(in_data);
        end
      end
    end
  end

  // Drive one cycle's inputs just after the edge, return just after the
  // following falling edge so the caller sees that cycle's outputs.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic oa,
                     input logic fl);
    @(posedge aclk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_allow = oa;
    flush     = fl;
    @(negedge aclk);
    #1;
  endtask

  initial begin
    areset    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_allow = 1'b0;
    nop_data  = WIDTH'(16'hDEAD);
    mon_en    = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Streaming with downstream always ready.
    cyc(1'b1, 'h11, 1'b1, 1'b0);
    check("s_first_valid", WIDTH'(out_valid), '0);
    check("s_first_count", WIDTH'(count), '0);
    cyc(1'b1, 'h22, 1'b1, 1'b0);
    check("s_data11", out_data, 'h11);
    check("s_count1", WIDTH'(count), 1);
    cyc(1'b1, 'h33, 1'b1, 1'b0);
    check("s_data22", out_data, 'h22);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("s_data33", out_data, 'h33);
    check("s_count1b", WIDTH'(count), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("s_empty", out_data, WIDTH'(16'hDEAD));

    // Fill with downstream stalled; fifth item held upstream.
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, WIDTH'(k), 1'b0, 1'b0);
      check("f_allow", WIDTH'(in_allow), 1);
      check("f_count", WIDTH'(count), WIDTH'(k - 1));
    end
    cyc(1'b1, 'd5, 1'b0, 1'b0);
    check("f_full_allow", WIDTH'(in_allow), '0);
    check("f_full_count", WIDTH'(count), 4);
    // Full plus pop in the same cycle: only the pop happens.
    cyc(1'b1, 'd5, 1'b1, 1'b0);
    check("f_pop_head", out_data, 'd1);
    check("f_pop_allow", WIDTH'(in_allow), '0);
    cyc(1'b1, 'd5, 1'b1, 1'b0);
    check("f_after_count", WIDTH'(count), 3);
    check("f_after_allow", WIDTH'(in_allow), 1);
    check("f_after_head", out_data, 'd2);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("f_hold_count", WIDTH'(count), 3);
    check("f_hold_head", out_data, 'd3);

    // Flush with three entries queued.
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("fl_valid", WIDTH'(out_valid), '0);
    check("fl_data", out_data, WIDTH'(16'hDEAD));
    cyc(1'b1, 'h44, 1'b0, 1'b0);
    check("fl_count0", WIDTH'(count), '0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("fl_head44", out_data, 'h44);

    // Push/pop pairs across pointer wrap; occupancy stays at one.
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      cyc(1'b1, WIDTH'(32'h100 + i), 1'b1, 1'b0);
      check("w_count", WIDTH'(count), 1);
      check("w_head", out_data, (i == 0) ? WIDTH'(32'h44) : WIDTH'(32'h100 + i - 1));
    end

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge aclk);
      #1;
      if (c == 1500) begin
        areset = 1'b1;
      end else if (c == 1503) begin
        areset = 1'b0;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rnd_data();
      out_allow = ($urandom_range(0, 2) != 0) ^ (c[8] & c[6]);
      flush     = ($urandom_range(0, 31) == 0);
      nop_data  = rnd_data();
    end
    @(posedge aclk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    out_allow = 1'b1;
    repeat (DEPTH + 2) @(posedge aclk);
    @(negedge aclk);
    #1;
    check("drain_count", WIDTH'(count), '0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
